pc_predict: RTL
===============

// Module: pc_predict
// PURPOSE
//   Parametrised fetch-stage PC unit with an integrated direct-mapped branch target buffer (BTB).
//   Holds the current word PC and predicts the next PC each cycle from BTB hit plus saturating counter.
//   Accepts redirects from decode (jumps) and from the branch-resolve stage (mispredicts).
//   Trains the BTB from resolved branches. Sits between the hazard unit and the instruction cache request.
// PARAMETERS
//   PC_W        30      word-address width (byte PC bits [PC_W+1:2])
//   RESET_PC    '0      word PC loaded on reset
//   BTB_ENTRIES 16      BTB depth; power of 2, >= 2; IDX_W = $clog2(BTB_ENTRIES)
//   CTR_W       2       prediction counter width, >= 1
// PORTS
//   CLK            in   1      clock, rising edge
//   RST            in   1      asynchronous reset, active-high
//   pcEN           in   1      advance PC this cycle (low = fetch stall)
//   jmp_valid      in   1      decode-stage unconditional redirect
//   jmp_target     in   PC_W   jump target word address
//   res_valid      in   1      branch resolved this cycle
//   res_pc         in   PC_W   word PC of the resolved branch
//   res_taken      in   1      actual outcome
//   res_target     in   PC_W   actual taken target
//   res_mispredict in   1      prediction was wrong; redirect required
//   res_redirect   in   PC_W   correct next PC after mispredict
//   cpc            out  PC_W   current fetch word PC
//   npc            out  PC_W   cpc + 1 (sequential), for pipeline link/fallthrough
//   pred_taken     out  1      BTB hit and counter MSB set for cpc
//   pred_target    out  PC_W   BTB target for cpc (valid when pred_taken)
// BEHAVIOUR
//   Reset (async, immediate): cpc=RESET_PC, npc=RESET_PC+1, pred_taken=0, all BTB valid bits=0.
//   npc = cpc+1 mod 2^PC_W (wraps to 0 at all-ones). pred_* are combinational from cpc and BTB.
//   Lookup: idx=cpc[IDX_W-1:0], tag=cpc[PC_W-1:IDX_W]; hit = valid[idx] && tag match.
//   Next-PC priority (one clock, registered into cpc):
//     1 res_valid && res_mispredict -> res_redirect; applies even when pcEN=0 (flush wins over stall)
//     2 jmp_valid && pcEN           -> jmp_target
//     3 pcEN && pred_taken          -> pred_target
//     4 pcEN                        -> npc
//     else hold cpc.
//   Training (res_valid, index/tag from res_pc):
//     hit: counter +1 if taken, -1 if not, saturating at 0 and 2^CTR_W-1; if taken, target <= res_target.
//     miss & taken: allocate/overwrite entry: valid=1, tag, target, counter = 2^(CTR_W-1) (weakly taken).
//     miss & not taken: no change.
//   Same-cycle lookup and update of the same index: lookup sees old contents (read-before-write).
//     New contents are visible the following cycle.
//   res_mispredict without res_valid is ignored.
//   CTR_W=1: counter is a single last-outcome bit; saturation is trivially the bit value.
//   Reset asserted mid-operation discards any in-flight update; no partial BTB write survives.
// STRUCTURE
//   Shared package pc_pkg: pcsrc_t enum (PC_REDIRECT, PC_JUMP, PC_PRED, PC_SEQ, PC_HOLD);
//     parameterised btb_entry_t {valid, tag, target, ctr} as a struct typedef inside pc_predict;
//     ctr_sat_inc/ctr_sat_dec functions.
//   Sub-module pc_btb: storage plus combinational lookup port and registered update port.
//   pc_predict holds the PC register, priority mux and training control.
// TESTING
//   Reset with RESET_PC=0x100: cpc=0x100, npc=0x101, pred_taken=0; 4 cycles of pcEN=1 -> cpc=0x104.
//   Resolve taken branch pc=0x104 target=0x200 (miss); next visit to 0x104 -> pred_taken=1, cpc then 0x200.
//   Two not-taken resolves at 0x104 (CTR_W=2): counter 2->1->0, pred_taken=0 after the first.
//   Mispredict with pcEN=0, res_redirect=0x300, jmp_valid=1 -> cpc=0x300 next cycle, jump ignored.
//   Alias: 0x104 and 0x114 (16 entries) -> taken at 0x114 evicts 0x104; 0x104 then misses.
//   cpc=all-ones, pcEN=1, no prediction -> npc=0, cpc wraps to 0; RST mid-run -> cpc=RESET_PC at once.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch-stage PC unit and its branch target buffer.
package pc_pkg;

  // Source selected for the next fetch PC, listed in priority order.
  typedef enum logic [2:0] {
    PC_REDIRECT,
    PC_JUMP,
    PC_PRED,
    PC_SEQ,
    PC_HOLD
  } pcsrc_t;

  // Widest prediction counter the helpers handle; callers zero-extend into this width.
  localparam int CTR_MAX_W = 8;

  // Saturating increment of a w-bit counter carried in a CTR_MAX_W-bit container.
  function automatic logic [CTR_MAX_W-1:0] ctr_sat_inc(input logic [CTR_MAX_W-1:0] ctr,
                                                       input int w);
    logic [CTR_MAX_W-1:0] top;
    top = CTR_MAX_W'((64'd1 << w) - 64'd1);
    return (ctr >= top) ? top : ctr + 1'b1;
  endfunction

  // Saturating decrement; a counter at zero stays at zero.
  function automatic logic [CTR_MAX_W-1:0] ctr_sat_dec(input logic [CTR_MAX_W-1:0] ctr);
    return (ctr == '0) ? '0 : ctr - 1'b1;
  endfunction

endpackage

// File: rtl/pc_btb.sv
// Direct-mapped BTB storage: two combinational read ports (fetch lookup and
// training read-modify-write) and one registered write port. Entries are
// opaque vectors here; the owner defines the field layout.
module pc_btb #(
  parameter int IDX_W   = 4,
  parameter int ENTRY_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [IDX_W-1:0]   lu_idx_i,
  output logic [ENTRY_W-1:0] lu_entry_o,
  input  logic [IDX_W-1:0]   rd_idx_i,
  output logic [ENTRY_W-1:0] rd_entry_o,
  input  logic               wr_en_i,
  input  logic [IDX_W-1:0]   wr_idx_i,
  input  logic [ENTRY_W-1:0] wr_entry_i
);

  localparam int DEPTH = 1 << IDX_W;

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  // Reads return the contents before any write landing on the same edge.
  always_comb begin
    lu_entry_o = mem_q[lu_idx_i];
    rd_entry_o = mem_q[rd_idx_i];
  end

  // Whole entries are cleared on reset so no half-written entry can survive it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_entry_i;
    end
  end

endmodule

// File: rtl/pc_predict.sv
// Fetch-stage PC unit: current PC register, next-PC priority mux and BTB
// training from resolved branches.
module pc_predict
  import pc_pkg::*;
#(
  parameter int              PC_W        = 30,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter int              BTB_ENTRIES = 16,
  parameter int              CTR_W       = 2
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            pcEN,
  input  logic            jmp_valid,
  input  logic [PC_W-1:0] jmp_target,
  input  logic            res_valid,
  input  logic [PC_W-1:0] res_pc,
  input  logic            res_taken,
  input  logic [PC_W-1:0] res_target,
  input  logic            res_mispredict,
  input  logic [PC_W-1:0] res_redirect,
  output logic [PC_W-1:0] cpc,
  output logic [PC_W-1:0] npc,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = PC_W - IDX_W;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [PC_W-1:0]  target;
    logic [CTR_W-1:0] ctr;
  } btb_entry_t;

  localparam int ENTRY_W = $bits(btb_entry_t);

  // Newly allocated entries start weakly taken: MSB set, rest clear.
  localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1 << (CTR_W - 1));

  logic [PC_W-1:0] cpc_q;
  logic [PC_W-1:0] cpc_d;
  pcsrc_t          pc_src;

  btb_entry_t lu_entry;
  btb_entry_t tr_entry;
  btb_entry_t wr_entry;
  logic       wr_en;
  logic       lu_hit;
  logic       tr_hit;

  logic [CTR_W-1:0] ctr_up;
  logic [CTR_W-1:0] ctr_down;

  pc_btb #(
    .IDX_W  (IDX_W),
    .ENTRY_W(ENTRY_W)
  ) u_btb (
    .clk_i     (CLK),
    .rst_i     (RST),
    .lu_idx_i  (cpc_q[IDX_W-1:0]),
    .lu_entry_o(lu_entry),
    .rd_idx_i  (res_pc[IDX_W-1:0]),
    .rd_entry_o(tr_entry),
    .wr_en_i   (wr_en),
    .wr_idx_i  (res_pc[IDX_W-1:0]),
    .wr_entry_i(wr_entry)
  );

  // Fetch-side prediction for the current PC, purely from cpc and BTB contents.
  always_comb begin
    lu_hit      = lu_entry.valid && (lu_entry.tag == cpc_q[PC_W-1:IDX_W]);
    pred_taken  = lu_hit && lu_entry.ctr[CTR_W-1];
    pred_target = lu_entry.target;
  end

  // Pick the next-PC source; a mispredict flush overrides a fetch stall.
  always_comb begin
    if (res_valid && res_mispredict) begin
      pc_src = PC_REDIRECT;
    end else if (pcEN && jmp_valid) begin
      pc_src = PC_JUMP;
    end else if (pcEN && pred_taken) begin
      pc_src = PC_PRED;
    end else if (pcEN) begin
      pc_src = PC_SEQ;
    end else begin
      pc_src = PC_HOLD;
    end
  end

  // Next-PC data mux driven by the selected source.
  always_comb begin
    unique case (pc_src)
      PC_REDIRECT: cpc_d = res_redirect;
      PC_JUMP:     cpc_d = jmp_target;
      PC_PRED:     cpc_d = pred_target;
      PC_SEQ:      cpc_d = npc;
      default:     cpc_d = cpc_q;
    endcase
  end

  // Current fetch PC register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cpc_q <= RESET_PC;
    end else begin
      cpc_q <= cpc_d;
    end
  end

  assign cpc = cpc_q;
  assign npc = cpc_q + PC_W'(1);

  // Saturating counter neighbours of the entry being trained.
  always_comb begin
    ctr_up   = CTR_W'(ctr_sat_inc(CTR_MAX_W'(tr_entry.ctr), CTR_W));
    ctr_down = CTR_W'(ctr_sat_dec(CTR_MAX_W'(tr_entry.ctr)));
  end

  // Training: update a hitting entry, allocate on a taken miss, ignore a not-taken miss.
  always_comb begin
    tr_hit   = tr_entry.valid && (tr_entry.tag == res_pc[PC_W-1:IDX_W]);
    wr_en    = 1'b0;
    wr_entry = tr_entry;
    if (res_valid) begin
      if (tr_hit) begin
        wr_en = 1'b1;
        if (res_taken) begin
          wr_entry.ctr    = ctr_up;
          wr_entry.target = res_target;
        end else begin
          wr_entry.ctr = ctr_down;
        end
      end else if (res_taken) begin
        wr_en           = 1'b1;
        wr_entry.valid  = 1'b1;
        wr_entry.tag    = res_pc[PC_W-1:IDX_W];
        wr_entry.target = res_target;
        wr_entry.ctr    = CTR_WEAK;
      end
    end
  end

endmodule
